// File: rtl/muldiv_stall_unit.sv
// muldiv_stall_unit
// Iterative RV32M multiply/divide unit for the EX stage. It raises a one-cycle
// stall request when an M-extension instruction issues, iterates one bit per
// cycle, and then pulses unstall in the same cycle that it presents the result
// for writeback. Divide-by-zero and signed overflow finish in one cycle.
//
// Ports:
//   clk            core clock, rising edge
//   rst            asynchronous active-low reset
//   start_i        issue request (valid M instruction in EX)
//   funct3_i       0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   rs1_i, rs2_i   operands A (dividend/multiplicand) and B (divisor/multiplier)
//   rd_i           destination register
//   flush_i        abort any in-flight operation
//   stall_req_o    one-cycle stall request (combinational, on issue)
//   unstall_o      one-cycle release of the stall-hold latch
//   busy_o         operation in progress (CALC or DONE)
//   result_valid_o result_o / rd_o valid for writeback this cycle
//   result_o       operation result
//   rd_o           destination register of the completed operation
module muldiv_stall_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_req_o,
  output logic            unstall_o,
  output logic            busy_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          funct3_q;
  logic [4:0]          rd_q;
  logic [XLEN-1:0]     addend_q;
  logic [2*XLEN-1:0]   acc_q;
  logic                neg_q;
  logic [XLEN-1:0]     result_q;
  logic                unstall_q;
  logic                valid_q;

  logic                accept;
  logic                isDivIn;
  logic                aSigned;
  logic                bSigned;
  logic                sA;
  logic                sB;
  logic [XLEN-1:0]     magA;
  logic [XLEN-1:0]     magB;
  logic                negIn;
  logic                divZero;
  logic                divOvf;
  logic [XLEN-1:0]     specialRes;

  logic [XLEN:0]       mulSum;
  logic [XLEN:0]       divShift;
  logic [XLEN:0]       divDiff;
  logic [2*XLEN-1:0]   acc_d;
  logic [2*XLEN-1:0]   prodSigned;
  logic [XLEN-1:0]     divRes;
  logic [XLEN-1:0]     divSigned;
  logic [XLEN-1:0]     final_d;
  logic                lastIter;

  assign accept = (state_q == IDLE) & start_i & ~flush_i;

  // Operand preparation at issue: signed operands become magnitudes and the
  // sign of the final result is remembered (remainder follows the dividend).
  always_comb begin
    isDivIn    = funct3_i[2];
    aSigned    = (funct3_i == 3'd1) | (funct3_i == 3'd2) |
                 (funct3_i == 3'd4) | (funct3_i == 3'd6);
    bSigned    = (funct3_i == 3'd1) | (funct3_i == 3'd4) | (funct3_i == 3'd6);
    sA         = aSigned & rs1_i[XLEN-1];
    sB         = bSigned & rs2_i[XLEN-1];
    magA       = sA ? -rs1_i : rs1_i;
    magB       = sB ? -rs2_i : rs2_i;
    negIn      = (funct3_i == 3'd6) ? sA : (sA ^ sB);
    divZero    = isDivIn & (rs2_i == '0);
    divOvf     = isDivIn & ~funct3_i[0] & (rs1_i == MIN_NEG) & (rs2_i == '1);
    specialRes = '0;
    if (divZero) begin
      specialRes = funct3_i[1] ? rs1_i : '1;
    end else begin
      specialRes = funct3_i[1] ? '0 : MIN_NEG;
    end
  end

  // One iteration step. The 2*XLEN accumulator is the product for multiply
  // (upper half adds, whole thing shifts right) and {remainder, quotient}
  // for restoring division (shift left, trial-subtract the divisor).
  always_comb begin
    mulSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, addend_q} : '0);
    divShift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    divDiff  = divShift - {1'b0, addend_q};
    acc_d    = {mulSum, acc_q[XLEN-1:1]};
    if (funct3_q[2]) begin
      if (divDiff[XLEN]) begin
        acc_d = {divShift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
        acc_d = {divDiff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end
    end
    prodSigned = neg_q ? -acc_d : acc_d;
    divRes     = funct3_q[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
    divSigned  = neg_q ? -divRes : divRes;
    if (funct3_q[2]) begin
      final_d = divSigned;
    end else if (funct3_q == 3'd0) begin
      final_d = prodSigned[XLEN-1:0];
    end else begin
      final_d = prodSigned[2*XLEN-1:XLEN];
    end
    lastIter = (cnt_q == CNT_W'(XLEN-1));
  end

  // Control FSM with registered unstall/valid. A flush in CALC returns to
  // IDLE but still schedules the unstall pulse so the hold latch is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      addend_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      result_q  <= '0;
      unstall_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      unstall_q <= 1'b0;
      valid_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            funct3_q <= funct3_i;
            rd_q     <= rd_i;
            neg_q    <= negIn;
            cnt_q    <= '0;
            if (divZero | divOvf) begin
              result_q  <= specialRes;
              unstall_q <= 1'b1;
              valid_q   <= 1'b1;
              state_q   <= DONE;
            end else begin
              addend_q <= isDivIn ? magB : magA;
              acc_q    <= {{XLEN{1'b0}}, (isDivIn ? magA : magB)};
              state_q  <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            unstall_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (lastIter) begin
              result_q  <= final_d;
              unstall_q <= 1'b1;
              valid_q   <= 1'b1;
              state_q   <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stall_req_o    = rst & accept;
  assign unstall_o      = unstall_q;
  assign busy_o         = (state_q != IDLE);
  assign result_valid_o = valid_q & ~flush_i;
  assign result_o       = result_q;
  assign rd_o           = rd_q;

endmodule
